window_sum_accumulator: RTL and testbench

- Sliding-window running sum over the last TAPS signed samples of a streaming pixel row.
- Typical input is a spatial or temporal derivative.
- Sits directly upstream of the divide-and-round stage, which takes this block's out with DIVISOR = TAPS to form the window average.
- Advances only on en, so the whole chain stalls together. Restarts the window at each start-of-line.

---
 rtl/window_sum_accumulator.sv | 120 ++++++++++++
 tb/tb_window_sum_accumulator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/window_sum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : window_sum_accumulator
//  Description : Sliding-window running sum over the last TAPS signed samples
//                of a streaming pixel row. The window restarts at each start
//                of line, and the block advances only when en is high, so the
//                whole pipeline stalls together. The output feeds a divide
//                stage with DIVISOR = TAPS to form the window average.
//  Ports       : clk       - single clock, rising-edge active
//                rst_n     - asynchronous active-low reset
//                en        - sample strobe / pipeline advance
//                sol       - start of line, qualified by en
//                in        - signed IN_WIDTH-bit sample
//                out       - signed OUT_WIDTH-bit registered window sum
//                out_valid - high when out covers a full TAPS-sample window
//  Revision    : 1.0 - initial release
// ============================================================================
module window_sum_accumulator #(
    parameter int IN_WIDTH  = 9,
    parameter int TAPS      = 8,
    parameter int OUT_WIDTH = IN_WIDTH + $clog2(TAPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sol,
    input  logic [IN_WIDTH-1:0]  in,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 out_valid
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (OUT_WIDTH < IN_WIDTH + $clog2(TAPS)) begin : g_bad_out_width
        $error("window_sum_accumulator: OUT_WIDTH too small for IN_WIDTH and TAPS");
    end

    if ((TAPS < 2) || ((TAPS & (TAPS - 1)) != 0)) begin : g_bad_taps
        $error("window_sum_accumulator: TAPS must be a power of two and >= 2");
    end

    // Fill counter must be able to hold the value TAPS itself.
    localparam int                 c_cnt_width = $clog2(TAPS + 1);
    localparam logic [c_cnt_width-1:0] c_cnt_full = c_cnt_width'(TAPS);
    localparam logic [c_cnt_width-1:0] c_cnt_one  = c_cnt_width'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // Delay line: index 0 holds the newest sample, TAPS-1 the oldest.
    // Samples are stored at input width and sign-extended when used.
    logic signed [IN_WIDTH-1:0]  r_taps [TAPS];
    logic signed [OUT_WIDTH-1:0] r_acc;
    logic [c_cnt_width-1:0]      r_cnt;
    logic [OUT_WIDTH-1:0]        r_out;
    logic                        r_out_valid;

    // ------------------------------------------------------------------
    // Next-state arithmetic
    // ------------------------------------------------------------------
    logic signed [OUT_WIDTH-1:0] w_in_ext;
    logic signed [OUT_WIDTH-1:0] w_oldest_ext;
    logic signed [OUT_WIDTH-1:0] w_acc_next;
    logic [c_cnt_width-1:0]      w_cnt_next;

    assign w_in_ext     = {{(OUT_WIDTH - IN_WIDTH){in[IN_WIDTH-1]}}, in};
    assign w_oldest_ext = {{(OUT_WIDTH - IN_WIDTH){r_taps[TAPS-1][IN_WIDTH-1]}},
                           r_taps[TAPS-1]};

    // Reset leaves the delay line, accumulator and count at zero, so the
    // first en cycle after reset computes exactly what a line restart would
    // even when sol is low: no separate "first sample" flag is needed.
    always_comb begin
        w_acc_next = r_acc + w_in_ext - w_oldest_ext;
        w_cnt_next = (r_cnt == c_cnt_full) ? r_cnt : r_cnt + c_cnt_one;
        if (sol) begin
            w_acc_next = w_in_ext;
            w_cnt_next = c_cnt_one;
        end
    end

    // ------------------------------------------------------------------
    // Newest tap, accumulator, fill count and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taps[0]   <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (en) begin
            r_taps[0]   <= in;
            r_acc       <= w_acc_next;
            r_cnt       <= w_cnt_next;
            r_out       <= w_acc_next;
            r_out_valid <= (w_cnt_next == c_cnt_full);
        end
    end

    // ------------------------------------------------------------------
    // Remaining taps: shift on a normal step, flush to zero on line
    // restart so that the previous row never contributes to the new one.
    // ------------------------------------------------------------------
    for (genvar i = 1; i < TAPS; i++) begin : g_delay
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_taps[i] <= '0;
            end else if (en) begin
                r_taps[i] <= sol ? '0 : r_taps[i-1];
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_window_sum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_window_sum_accumulator
//  Description : Self-checking bench for window_sum_accumulator: a table of
//                directed vectors, hand-written stall and async-reset
//                sequences, and randomized stimulus against a queue-based
//                window model. A shadow check confirms the accumulator equals
//                the sum of the delay line on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_window_sum_accumulator;

    localparam int IN_WIDTH  = 9;
    localparam int TAPS      = 8;
    localparam int OUT_WIDTH = 12;

    logic                 clk;
    logic                 rst_n;
    logic                 en;
    logic                 sol;
    logic [IN_WIDTH-1:0]  in;
    logic [OUT_WIDTH-1:0] out;
    logic                 out_valid;

    int checks;
    int errors;

    window_sum_accumulator #(
        .IN_WIDTH  (IN_WIDTH),
        .TAPS      (TAPS),
        .OUT_WIDTH (OUT_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sol       (sol),
        .in        (in),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: the current row's samples, at most TAPS of them.
    // ------------------------------------------------------------------
    int win[$];
    bit first_after_reset;

    task automatic model_reset();
        win.delete();
        first_after_reset = 1'b1;
    endtask

    task automatic model_step(input bit e, input bit s, input int d);
        if (e) begin
            if (s || first_after_reset) begin
                win.delete();
                first_after_reset = 1'b0;
            end
            win.push_back(d);
            if (win.size() > TAPS) win = win[1:$];
        end
    endtask

    function automatic int model_out();
        int sum;
        sum = 0;
        foreach (win[k]) sum += win[k];
        return sum;
    endfunction

    function automatic int model_valid();
        return (win.size() == TAPS) ? 1 : 0;
    endfunction

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    function automatic int dut_out();
        logic signed [OUT_WIDTH-1:0] v;
        v = out;
        return int'(v);
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(input string nm);
        check({nm, "_out"},   dut_out(),       model_out());
        check({nm, "_valid"}, int'(out_valid), model_valid());
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later.
    task automatic cycle(input bit e, input bit s, input int d);
        logic [31:0] dv;
        dv  = d;
        en  = e;
        sol = s;
        in  = dv[IN_WIDTH-1:0];
        @(posedge clk);
        #1;
        model_step(e, s, d);
    endtask

    // Shadow-sum integrity: accumulator must equal the delay-line sum.
    always @(negedge clk) begin
        int s;
        if (rst_n) begin
            s = 0;
            for (int k = 0; k < TAPS; k++) s += int'(dut.r_taps[k]);
            checks++;
            if (s != int'(dut.r_acc)) begin
                errors++;
                $display("FAIL shadow_sum actual=%0d required=%0d at %0t",
                         int'(dut.r_acc), s, $time);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit en;
        bit sol;
        int din;
        int exp_out;
        bit exp_valid;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit e, input bit s, input int d,
                                input int eo, input bit ev);
        vec_t v;
        v.en = e; v.sol = s; v.din = d; v.exp_out = eo; v.exp_valid = ev;
        vecs.push_back(v);
    endfunction

    initial begin
        int gap;
        int n;

        checks = 0;
        errors = 0;

        // Ones: out steps 1..8, valid only once the 8th sample lands.
        for (int k = 1; k <= 10; k++)
            add(1'b1, k == 1, 1, (k < 8) ? k : 8, k >= 8);
        // Extremes: most negative, then most positive, with no wrap.
        for (int k = 1; k <= 8; k++)
            add(1'b1, k == 1, -256, -256 * k, k == 8);
        for (int k = 1; k <= 8; k++)
            add(1'b1, 1'b0, 255, -2048 + 511 * k, 1'b1);
        // Ramp 0..15 from a line start.
        for (int k = 0; k <= 15; k++)
            add(1'b1, k == 0, k, (k < 7) ? k * (k + 1) / 2 : 8 * k - 28, k >= 7);
        // Line restart: twelve 5s, then a new row of 3s.
        for (int k = 1; k <= 12; k++)
            add(1'b1, k == 1, 5, 5 * ((k < 8) ? k : 8), k >= 8);
        for (int k = 1; k <= 8; k++)
            add(1'b1, k == 1, 3, 3 * k, k == 8);

        // ---------------- Reset state ----------------
        rst_n = 1'b0; en = 1'b0; sol = 1'b0; in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_out",   dut_out(),       0);
        check("reset_valid", int'(out_valid), 0);
        rst_n = 1'b1;

        // ---------------- Table ----------------
        foreach (vecs[k]) begin
            cycle(vecs[k].en, vecs[k].sol, vecs[k].din);
            check("tbl_out",   dut_out(),       vecs[k].exp_out);
            check("tbl_valid", int'(out_valid), int'(vecs[k].exp_valid));
        end

        // ---------------- Stalled ramp ----------------
        for (int k = 0; k <= 15; k++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                // sol and in are junk while en is low and must be ignored
                cycle(1'b0, ($urandom_range(0, 1) == 1), $urandom_range(0, 511) - 256);
                check_model("stall_hold");
            end
            cycle(1'b1, k == 0, k);
            check("stall_out",   dut_out(), (k < 7) ? k * (k + 1) / 2 : 8 * k - 28);
            check("stall_valid", int'(out_valid), (k >= 7) ? 1 : 0);
        end

        // ---------------- Async reset mid-window ----------------
        for (int k = 0; k < 5; k++) cycle(1'b1, k == 0, 9);
        check_model("pre_reset");
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_out",   dut_out(),       0);
        check("async_rst_valid", int'(out_valid), 0);
        #2 rst_n = 1'b1;
        cycle(1'b1, 1'b0, 7);
        check("post_rst_out",   dut_out(),       7);
        check("post_rst_valid", int'(out_valid), 0);
        for (int k = 2; k <= 8; k++) begin
            cycle(1'b1, 1'b0, 7);
            check("post_rst_fill_out", dut_out(), 7 * k);
            check("post_rst_fill_valid", int'(out_valid), (k == 8) ? 1 : 0);
        end

        // ---------------- Single-sample rows ----------------
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b1, 100 - 50 * k);
            check("single_row_out",   dut_out(),       100 - 50 * k);
            check("single_row_valid", int'(out_valid), 0);
        end

        // ---------------- Randomized against the model ----------------
        n = 0;
        while (n < 600) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                  $urandom_range(0, 511) - 256);
            check_model("rand");
            n++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
